// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a three-state memory handshake FSM and the
//   IF/ID pipeline register.
//
//   The request to instruction memory is always valid. A request that is not
//   answered in its issue cycle is latched and held until the memory answers.
//   A redirect (taken branch or writeback PC write) that arrives while a
//   request is outstanding marks that request's returning word as stale. The
//   word is then discarded instead of being written into IF/ID.
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous active-low reset
//   StallF        : hold PC
//   StallD        : hold IF/ID (StallD=1 implies StallF=1)
//   FlushD        : replace IF/ID contents with a bubble
//   PCSrcW        : writeback redirect, target ResultW
//   BranchTakenE  : execute-stage redirect, target ALUResultE (wins over PCSrcW)
//   ResultW       : writeback redirect target
//   ALUResultE    : branch target
//   ImemReqF      : instruction memory request (always 1 out of reset)
//   ImemAddrF     : word-aligned request address
//   ImemRdyF      : memory returns ImemRDataF for the held request this cycle
//   ImemRDataF    : instruction word from memory
//   InstrD        : decode-stage instruction
//   PCPlus8D      : fetch address of InstrD plus 8
//   ValidD        : InstrD is a real instruction (0 = bubble)
//   FetchWaitF    : fetch is blocked waiting on memory
// -----------------------------------------------------------------------------
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcW,
  input  logic        BranchTakenE,
  input  logic [31:0] ResultW,
  input  logic [31:0] ALUResultE,
  output logic        ImemReqF,
  output logic [31:0] ImemAddrF,
  input  logic        ImemRdyF,
  input  logic [31:0] ImemRDataF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD,
  output logic        FetchWaitF
);

  localparam logic [1:0] ST_FETCH     = 2'd0;
  localparam logic [1:0] ST_WAIT      = 2'd1;
  localparam logic [1:0] ST_WAIT_DROP = 2'd2;

  // Addresses are held as word indices so the low two bits are zero by
  // construction; PC+4 becomes index+1 and wraps naturally at 2^30.
  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic [29:0] pc_r;
  logic [29:0] req_r;
  logic [29:0] fetch_addr_s;
  logic [29:0] target_s;
  logic        redirect_s;
  logic        complete_s;
  logic        capture_s;

  // Redirect decode, current request address and fetch outcome.
  always_comb begin
    redirect_s = BranchTakenE | PCSrcW;
    if (BranchTakenE) begin
      target_s = ALUResultE[31:2];
    end else begin
      target_s = ResultW[31:2];
    end
    if (state_r == ST_FETCH) begin
      fetch_addr_s = pc_r;
    end else begin
      fetch_addr_s = req_r;
    end
    // A word answered in WAIT_DROP belongs to an abandoned path.
    complete_s = ImemRdyF & (state_r != ST_WAIT_DROP);
    // A redirect in the same cycle also makes the returning word stale.
    capture_s  = complete_s & ~redirect_s;
  end

  // Memory handshake FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (ImemRdyF) begin
          state_next_s = ST_FETCH;
        end else if (redirect_s) begin
          state_next_s = ST_WAIT_DROP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ImemRdyF) begin
          state_next_s = ST_FETCH;
        end else if (redirect_s) begin
          state_next_s = ST_WAIT_DROP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WAIT_DROP: begin
        if (ImemRdyF) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_WAIT_DROP;
        end
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // FSM state, PC and latched request address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FETCH;
      pc_r    <= 30'd0;
      req_r   <= 30'd0;
    end else begin
      state_r <= state_next_s;
      // The unanswered address stays on the bus while PC may be redirected.
      if ((state_r == ST_FETCH) && !ImemRdyF) begin
        req_r <= pc_r;
      end else begin
        req_r <= req_r;
      end
      if (redirect_s) begin
        pc_r <= target_s;
      end else if (capture_s && !StallF) begin
        pc_r <= fetch_addr_s + 30'd1;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= 32'd0;
      PCPlus8D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= 32'd0;
      PCPlus8D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus8D <= PCPlus8D;
      ValidD   <= ValidD;
    end else if (capture_s) begin
      InstrD   <= ImemRDataF;
      PCPlus8D <= {fetch_addr_s, 2'b00} + 32'd8;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= 32'd0;
      PCPlus8D <= 32'd0;
      ValidD   <= 1'b0;
    end
  end

  assign ImemReqF   = 1'b1;
  assign ImemAddrF  = {fetch_addr_s, 2'b00};
  assign FetchWaitF = (state_r != ST_FETCH);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. A request-level reference model tracks
//   the PC, whether a memory request is outstanding and whether it is stale,
//   and the IF/ID contents. Each driven cycle pushes the expected post-edge
//   outputs; an independent monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcW, BranchTakenE;
  logic [31:0] ResultW, ALUResultE;
  logic        ImemReqF;
  logic [31:0] ImemAddrF;
  logic        ImemRdyF;
  logic [31:0] ImemRDataF;
  logic [31:0] InstrD, PCPlus8D;
  logic        ValidD, FetchWaitF;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] addr;
    logic        valid;
    logic        waitf;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [31:0] m_pc, m_hold, m_instr, m_pc8;
  bit          m_busy, m_drop, m_valid;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .ResultW(ResultW), .ALUResultE(ALUResultE), .ImemReqF(ImemReqF),
    .ImemAddrF(ImemAddrF), .ImemRdyF(ImemRdyF), .ImemRDataF(ImemRDataF),
    .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
    .FetchWaitF(FetchWaitF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b01} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_hold = 32'd0; m_instr = 32'd0; m_pc8 = 32'd0;
    m_busy = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
  endtask

  // Drive one cycle (called just after a falling edge), advance the model,
  // queue the expected post-edge outputs, then wait for the next falling edge.
  task automatic step(input bit sf, input bit sd, input bit fl, input bit ps,
                      input bit bt, input logic [31:0] res, input logic [31:0] alu,
                      input bit rdy);
    logic [31:0] addr, tgt;
    bit redir, useful;
    exp_t e;
    addr = m_busy ? m_hold : m_pc;
    StallF = sf; StallD = sd; FlushD = fl; PCSrcW = ps; BranchTakenE = bt;
    ResultW = res; ALUResultE = alu; ImemRdyF = rdy;
    ImemRDataF = mem_word(addr);
    redir  = ps | bt;
    tgt    = (bt ? alu : res) & 32'hFFFF_FFFC;
    useful = rdy && !m_drop && !redir;
    if (fl) begin
      m_instr = 32'd0; m_pc8 = 32'd0; m_valid = 1'b0;
    end else if (sd) begin
      // hold
    end else if (useful) begin
      m_instr = mem_word(addr); m_pc8 = addr + 32'd8; m_valid = 1'b1;
    end else begin
      m_instr = 32'd0; m_pc8 = 32'd0; m_valid = 1'b0;
    end
    if (redir) m_pc = tgt;
    else if (useful && !sf) m_pc = addr + 32'd4;
    if (rdy) begin
      m_busy = 1'b0; m_drop = 1'b0;
    end else begin
      m_busy = 1'b1; m_hold = addr; m_drop = m_drop | redir;
    end
    e.instr = m_instr; e.pc8 = m_pc8; e.valid = m_valid;
    e.addr  = m_busy ? m_hold : m_pc; e.waitf = m_busy;
    exp_q.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  task automatic rand_step();
    bit sf, sd;
    logic [31:0] r, a;
    sf = ($urandom_range(0, 7) == 0);
    sd = sf && ($urandom_range(0, 1) == 1);
    r  = $urandom;
    a  = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h0000_000F)) : $urandom;
    step(sf, sd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 13) == 0),
         ($urandom_range(0, 13) == 0), r, a, ($urandom_range(0, 3) != 0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_instr"}, InstrD, 32'd0);
    check({tag, "_pc8"},   PCPlus8D, 32'd0);
    check({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
    check({tag, "_wait"},  {31'd0, FetchWaitF}, 32'd0);
    check({tag, "_addr"},  ImemAddrF, 32'd0);
    check({tag, "_req"},   {31'd0, ImemReqF}, 32'd1);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("instr_d",  InstrD,   e.instr);
      check("pcplus8d", PCPlus8D, e.pc8);
      check("valid_d",  {31'd0, ValidD}, {31'd0, e.valid});
      check("imem_addr", ImemAddrF, e.addr);
      check("fetch_wait", {31'd0, FetchWaitF}, {31'd0, e.waitf});
      check("imem_req", {31'd0, ImemReqF}, 32'd1);
    end
  end

  initial begin
    reset = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcW = 1'b0; BranchTakenE = 1'b0;
    ResultW = 32'd0; ALUResultE = 32'd0; ImemRdyF = 1'b1; ImemRDataF = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("in_reset");
    reset = 1'b1; #1;
    check_reset_values("after_release");

    // zero-wait stream from reset: 0, 4, 8 then 0xC
    repeat (4) idle(1'b1);

    // three wait states at 0x10, then the word arrives
    repeat (3) idle(1'b0);
    idle(1'b1);

    // go to 0x20, stall there, branch to 0x100 while waiting
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h0000_0020, 1'b1);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h0000_0100, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // simultaneous branch (0x200) and PC write (0x300): branch wins
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0200, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // stall two cycles, then flush while stalled
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    idle(1'b1);

    // unaligned target, then wrap from 0xFFFFFFFC to 0
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    repeat (3) idle(1'b1);

    // randomized traffic
    repeat (2000) rand_step();

    // asynchronous reset while a request is outstanding
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    check("wait_before_reset", {31'd0, FetchWaitF}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    repeat (3) idle(1'b1);
    repeat (500) rand_step();

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-003 StallF  input  1  hold PC (from hazard control).
REQ-004 StallD  input  1  hold IF/ID register; contract: StallD=1 implies StallF=1.
REQ-005 FlushD  input  1  replace IF/ID contents with bubble.
REQ-006 PCSrcW  input  1  writeback stage writes PC; target ResultW.
REQ-007 BranchTakenE  input  1  branch resolved taken in execute; target ALUResultE.
REQ-008 ResultW  input  32  PC-write target.
REQ-009 ALUResultE  input  32  branch target.
REQ-010 ImemReqF  output  1  instruction memory request valid.
REQ-011 ImemAddrF  output  32  request address, word aligned.
REQ-012 ImemRdyF  input  1  memory returns ImemRDataF this cycle for the held request.
REQ-013 ImemRDataF  input  32  instruction word.
REQ-014 InstrD  output  32  decode-stage instruction.
REQ-015 PCPlus8D  output  32  fetch address + 8 of InstrD.
REQ-016 ValidD  output  1  InstrD is a real instruction (0 = bubble).
REQ-017 FetchWaitF  output  1  fetch blocked on memory (FSM in WAIT or WAIT_DROP).

Function
REQ-018 PCF is a 32-bit register; ImemAddrF SHALL equal PCF in FETCH and the latched request address in WAIT/WAIT_DROP; bits [1:0] always 0.
REQ-019 FSM states FETCH, WAIT, WAIT_DROP; ImemReqF SHALL be 1 in all three.
REQ-020 FETCH: ImemRdyF=1 -> fetch completes, stay FETCH; ImemRdyF=0 -> latch ImemAddrF, go WAIT (WAIT_DROP if a redirect occurs that cycle).
REQ-021 WAIT: ImemRdyF=1 -> fetch completes, go FETCH; redirect with ImemRdyF=0 -> WAIT_DROP; redirect with ImemRdyF=1 -> returned word discarded, go FETCH.
REQ-022 WAIT_DROP: ImemRdyF=1 -> word discarded, go FETCH; else stay; ImemAddrF held stable until ImemRdyF.
REQ-023 Redirect next-PC priority: BranchTakenE -> ALUResultE; else PCSrcW -> ResultW; else PC+4 on completed fetch.
REQ-024 Redirect SHALL load PCF regardless of StallF and FSM state; low 2 target bits forced to 0.
REQ-025 Without redirect, PCF <= PCF+4 (mod 2^32, 0xFFFFFFFC wraps to 0) only when fetch completes and StallF=0; otherwise hold.
REQ-026 IF/ID priority: FlushD -> InstrD=0, ValidD=0, PCPlus8D=0; else StallD -> hold all; else completed non-discarded fetch -> InstrD=ImemRDataF, PCPlus8D=fetch address+8, ValidD=1; else bubble.
REQ-027 Redirect cycle SHALL NOT capture a word into IF/ID as valid (hazard control asserts FlushD; block enforces ValidD=0 independently).
REQ-028 Latency: instruction fetched at address A with zero wait states appears on InstrD one cycle after ImemReqF with ImemAddrF=A.

Reset
REQ-029 reset=0: PCF=0, FSM=FETCH, InstrD=0, PCPlus8D=0, ValidD=0, FetchWaitF=0; ImemReqF=1 with ImemAddrF=0 from first cycle after release.
REQ-030 Reset mid-WAIT abandons the outstanding request; memory SHALL tolerate the dropped request.

Verification
REQ-031 Zero-wait stream from reset, ImemRDataF=addr-tagged -> InstrD sequence addr 0,4,8 with PCPlus8D 8,12,16, ValidD=1 from cycle 2.
REQ-032 ImemRdyF low 3 cycles at A=0x10 -> FetchWaitF=1 three cycles, ImemAddrF stable 0x10, ValidD=0 those cycles, then InstrD=word@0x10.
REQ-033 BranchTakenE=1, ALUResultE=0x100 while in WAIT at 0x20 -> WAIT_DROP; word@0x20 discarded; next request 0x100.
REQ-034 BranchTakenE=1 (0x200) and PCSrcW=1 (0x300) same cycle -> PCF=0x200.
REQ-035 StallF=StallD=1 two cycles -> PCF, InstrD, PCPlus8D, ValidD unchanged; FlushD with StallD -> ValidD=0.
REQ-036 reset asserted asynchronously mid-WAIT -> all outputs at REQ-029 values before next clk edge.
